// File: rtl/tile_eoc_pkg.sv
// Shared types and defaults for the end-of-computation / console sniffer.
package tile_eoc_pkg;

    localparam int          TE_ADDR_W     = 32;
    localparam int          TE_DATA_W     = 32;
    localparam logic [31:0] EOC_ADDR_DEF  = 32'h1C00_0000;
    localparam logic [31:0] PUTC_ADDR_DEF = 32'h1C00_0004;

    typedef struct packed {
        logic [TE_ADDR_W-1:0] addr;
        logic                 burst;
    } aw_entry_t;

    typedef struct packed {
        logic [TE_DATA_W-1:0]   data;
        logic [TE_DATA_W/8-1:0] strb;
        logic                   last;
    } w_entry_t;

    typedef enum logic [0:0] {
        ST_PAIR        = 1'b0,
        ST_DRAIN_BURST = 1'b1
    } sniff_state_t;

    function automatic logic strb_all_ones(input logic [TE_DATA_W/8-1:0] strb);
        return &strb;
    endfunction

endpackage

// File: rtl/sniff_fifo.sv
// Small synchronous FIFO; pointers carry an extra MSB so full and empty differ.
module sniff_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    T            mem_r [DEPTH];
    logic [PW:0] wr_ptr_r;
    logic [PW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    // Occupancy flags and the accepted push/pop; a full FIFO takes a push only alongside a pop
    always_comb begin
        count     = wr_ptr_r - rd_ptr_r;
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        pop_data  = mem_r[rd_ptr_r[PW-1:0]];
    end

    // Storage and pointer update
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= T'('0);
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[PW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tile_eoc_sniffer.sv
// Passive AW/W observer: pairs write beats, raises EOC on the exit register
// and feeds console characters into a valid/ready FIFO.
module tile_eoc_sniffer
    import tile_eoc_pkg::*;
#(
    parameter int          ADDR_W     = TE_ADDR_W,
    parameter int          DATA_W     = TE_DATA_W,
    parameter logic [31:0] EOC_ADDR   = EOC_ADDR_DEF,
    parameter logic [31:0] PUTC_ADDR  = PUTC_ADDR_DEF,
    parameter int          Q_DEPTH    = 4,
    parameter int          CHAR_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                aw_valid,
    input  logic                aw_ready,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic                w_valid,
    input  logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                eoc_o,
    output logic [31:0]         exit_code_o,
    output logic                char_valid_o,
    output logic [7:0]          char_o,
    input  logic                char_ready_i,
    output logic                proto_err_o
);

    aw_entry_t    aw_in_s;
    aw_entry_t    aw_head_s;
    w_entry_t     w_in_s;
    w_entry_t     w_head_s;
    logic         aw_beat_s;
    logic         w_beat_s;
    logic         aw_push_s;
    logic         w_push_s;
    logic         aw_pop_s;
    logic         w_pop_s;
    logic         aw_full_s;
    logic         aw_empty_s;
    logic         w_full_s;
    logic         w_empty_s;
    logic         pair_avail_s;
    logic         pair_single_s;
    logic         char_push_s;
    logic         char_pop_s;
    logic         char_full_s;
    logic         char_empty_s;
    logic [7:0]   char_head_s;
    logic         err_set_s;
    logic [$clog2(Q_DEPTH):0]    aw_count_unused_s;
    logic [$clog2(Q_DEPTH):0]    w_count_unused_s;
    logic [$clog2(CHAR_DEPTH):0] char_count_unused_s;
    sniff_state_t state_r;

    // Handshake capture; a beat arriving at a full queue is dropped before any pop this cycle
    always_comb begin
        aw_beat_s     = aw_valid & aw_ready;
        w_beat_s      = w_valid & w_ready;
        aw_push_s     = aw_beat_s & ~aw_full_s;
        w_push_s      = w_beat_s & ~w_full_s;
        aw_in_s.addr  = aw_addr;
        aw_in_s.burst = (aw_len != 8'd0);
        w_in_s.data   = w_data;
        w_in_s.strb   = w_strb;
        w_in_s.last   = w_last;
    end

    sniff_fifo #(.T(aw_entry_t), .DEPTH(Q_DEPTH)) u_aw_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aw_push_s),
        .push_data (aw_in_s),
        .pop       (aw_pop_s),
        .pop_data  (aw_head_s),
        .full      (aw_full_s),
        .empty     (aw_empty_s),
        .count     (aw_count_unused_s)
    );

    sniff_fifo #(.T(w_entry_t), .DEPTH(Q_DEPTH)) u_w_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_s),
        .push_data (w_in_s),
        .pop       (w_pop_s),
        .pop_data  (w_head_s),
        .full      (w_full_s),
        .empty     (w_empty_s),
        .count     (w_count_unused_s)
    );

    // Pairing: bursts hold the AW head and drain W until its last beat
    always_comb begin
        aw_pop_s      = 1'b0;
        w_pop_s       = 1'b0;
        pair_single_s = 1'b0;
        pair_avail_s  = ~aw_empty_s & ~w_empty_s;
        if (pair_avail_s) begin
            if ((state_r == ST_DRAIN_BURST) || aw_head_s.burst) begin
                w_pop_s  = 1'b1;
                aw_pop_s = w_head_s.last;
            end else begin
                w_pop_s       = 1'b1;
                aw_pop_s      = 1'b1;
                pair_single_s = 1'b1;
            end
        end else begin
            aw_pop_s      = 1'b0;
            w_pop_s       = 1'b0;
            pair_single_s = 1'b0;
        end
    end

    // Console decode and sticky-error sources
    always_comb begin
        char_push_s = 1'b0;
        char_pop_s  = char_ready_i & ~char_empty_s;
        err_set_s   = (aw_beat_s & aw_full_s) | (w_beat_s & w_full_s);
        if (pair_single_s && (aw_head_s.addr == PUTC_ADDR) && w_head_s.strb[0]) begin
            char_push_s = 1'b1;
            err_set_s   = err_set_s | (char_full_s & ~char_pop_s);
        end else begin
            char_push_s = 1'b0;
        end
        if (pair_single_s && (aw_head_s.addr == EOC_ADDR) && !strb_all_ones(w_head_s.strb)) begin
            err_set_s = 1'b1;
        end else if (pair_avail_s && (state_r == ST_PAIR) && aw_head_s.burst) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end
    end

    sniff_fifo #(.T(logic [7:0]), .DEPTH(CHAR_DEPTH)) u_char_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (char_push_s),
        .push_data (w_head_s.data[7:0]),
        .pop       (char_pop_s),
        .pop_data  (char_head_s),
        .full      (char_full_s),
        .empty     (char_empty_s),
        .count     (char_count_unused_s)
    );

    // The FIFO head is register state, so it is already stable for the consumer
    always_comb begin
        char_valid_o = ~char_empty_s;
        char_o       = char_head_s;
    end

    // Pairing FSM, EOC capture and sticky error
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= ST_PAIR;
            eoc_o       <= 1'b0;
            exit_code_o <= 32'h0000_0000;
            proto_err_o <= 1'b0;
        end else begin
            if (err_set_s) begin
                proto_err_o <= 1'b1;
            end
            if (pair_avail_s) begin
                case (state_r)
                    ST_PAIR: begin
                        if (aw_head_s.burst && !w_head_s.last) begin
                            state_r <= ST_DRAIN_BURST;
                        end
                    end
                    ST_DRAIN_BURST: begin
                        if (w_head_s.last) begin
                            state_r <= ST_PAIR;
                        end
                    end
                    default: state_r <= ST_PAIR;
                endcase
            end
            // The first complete EOC write wins; later ones are ignored
            if (pair_single_s && (aw_head_s.addr == EOC_ADDR) &&
                strb_all_ones(w_head_s.strb) && !eoc_o) begin
                eoc_o       <= 1'b1;
                exit_code_o <= w_head_s.data[31:0];
            end
        end
    end

endmodule

// File: tb/tb_tile_eoc_sniffer.sv
// Directed bench for tile_eoc_sniffer; reset is active-high on rst_n.
module tb_tile_eoc_sniffer;

    logic        clk;
    logic        rst_n;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        eoc_o;
    logic [31:0] exit_code_o;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        char_ready_i;
    logic        proto_err_o;

    int checks;
    int errors;
    logic [7:0] exp_chars [17];

    localparam logic [31:0] EOC  = 32'h1C00_0000;
    localparam logic [31:0] PUTC = 32'h1C00_0004;

    tile_eoc_sniffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .aw_valid     (aw_valid),
        .aw_ready     (aw_ready),
        .aw_addr      (aw_addr),
        .aw_len       (aw_len),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .w_last       (w_last),
        .eoc_o        (eoc_o),
        .exit_code_o  (exit_code_o),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .char_ready_i (char_ready_i),
        .proto_err_o  (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len);
        aw_valid = 1'b1;
        aw_ready = 1'b1;
        aw_addr  = addr;
        aw_len   = len;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        w_valid = 1'b1;
        w_ready = 1'b1;
        w_data  = data;
        w_strb  = strb;
        w_last  = last;
    endtask

    task automatic clear_bus();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
    endtask

    task automatic do_reset();
        clear_bus();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_chars[0] = 8'h48; exp_chars[1] = 8'h45; exp_chars[2] = 8'h4C;
        exp_chars[3] = 8'h4C; exp_chars[4] = 8'h4F;
        for (int i = 0; i < 12; i++) exp_chars[5+i] = 8'h61 + 8'(i);
        rst_n = 1'b1; aw_valid = 1'b0; aw_ready = 1'b0; aw_addr = 32'h0; aw_len = 8'h0;
        w_valid = 1'b0; w_ready = 1'b0; w_data = 32'h0; w_strb = 4'h0; w_last = 1'b0;
        char_ready_i = 1'b0;

        // Reset state
        step();
        check("rst_eoc", {31'h0, eoc_o}, 32'h0);
        check("rst_exit", exit_code_o, 32'h0);
        check("rst_cvalid", {31'h0, char_valid_o}, 32'h0);
        check("rst_char", {24'h0, char_o}, 32'h0);
        check("rst_perr", {31'h0, proto_err_o}, 32'h0);
        rst_n = 1'b0;
        step();

        // 1: EOC write, exit code 0, two-edge latency
        drive_aw(EOC, 8'h00); drive_w(32'h0, 4'hF, 1'b1);
        step(); clear_bus();
        check("t1_eoc_latency", {31'h0, eoc_o}, 32'h0);
        step();
        check("t1_eoc", {31'h0, eoc_o}, 32'h1);
        check("t1_exit", exit_code_o, 32'h0);
        check("t1_perr", {31'h0, proto_err_o}, 32'h0);

        // 2: W precedes AW for a PUTC
        do_reset();
        drive_w(32'h41, 4'h1, 1'b1);
        step(); clear_bus();
        step(); step();
        check("t2_no_char_yet", {31'h0, char_valid_o}, 32'h0);
        drive_aw(PUTC, 8'h00);
        step(); clear_bus();
        check("t2_char_latency", {31'h0, char_valid_o}, 32'h0);
        step();
        check("t2_cvalid", {31'h0, char_valid_o}, 32'h1);
        check("t2_char", {24'h0, char_o}, 32'h41);
        step(); step();
        check("t2_cvalid_held", {31'h0, char_valid_o}, 32'h1);
        check("t2_char_held", {24'h0, char_o}, 32'h41);
        char_ready_i = 1'b1;
        step();
        char_ready_i = 1'b0;
        check("t2_drained", {31'h0, char_valid_o}, 32'h0);

        // 3: 17 characters into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive_aw(PUTC, 8'h00); drive_w({24'h0, exp_chars[i]}, 4'h1, 1'b1);
            step();
        end
        clear_bus();
        check("t3_no_err_at_16", {31'h0, proto_err_o}, 32'h0);
        step();
        check("t3_overflow_err", {31'h0, proto_err_o}, 32'h1);
        char_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_cvalid", {31'h0, char_valid_o}, 32'h1);
            check("t3_char", {24'h0, char_o}, {24'h0, exp_chars[i]});
            step();
        end
        char_ready_i = 1'b0;
        check("t3_empty", {31'h0, char_valid_o}, 32'h0);

        // 4: first EOC wins
        do_reset();
        drive_aw(EOC, 8'h00); drive_w(32'h5, 4'hF, 1'b1);
        step(); clear_bus(); step();
        check("t4_exit_first", exit_code_o, 32'h5);
        drive_aw(EOC, 8'h00); drive_w(32'h7, 4'hF, 1'b1);
        step(); clear_bus(); step(); step();
        check("t4_exit_kept", exit_code_o, 32'h5);
        check("t4_eoc", {31'h0, eoc_o}, 32'h1);
        check("t4_perr", {31'h0, proto_err_o}, 32'h0);

        // 5: burst to EOC is not decoded and keeps queues aligned
        do_reset();
        drive_aw(EOC, 8'h03); drive_w(32'hAA, 4'hF, 1'b0);
        step(); aw_valid = 1'b0;
        drive_w(32'hBB, 4'hF, 1'b0); step();
        drive_w(32'hCC, 4'hF, 1'b0); step();
        drive_w(32'hDD, 4'hF, 1'b1); step();
        clear_bus();
        check("t5_burst_perr", {31'h0, proto_err_o}, 32'h1);
        check("t5_burst_no_eoc", {31'h0, eoc_o}, 32'h0);
        drive_aw(EOC, 8'h00); drive_w(32'h2, 4'hF, 1'b1);
        step(); clear_bus(); step();
        check("t5_eoc", {31'h0, eoc_o}, 32'h1);
        check("t5_exit", exit_code_o, 32'h2);

        // 6: reset mid-burst with two AW entries queued
        do_reset();
        drive_aw(EOC, 8'h03); drive_w(32'h11, 4'hF, 1'b0);
        step();
        drive_aw(EOC, 8'h00); drive_w(32'h22, 4'hF, 1'b0);
        step(); clear_bus();
        check("t6_pre_perr", {31'h0, proto_err_o}, 32'h1);
        rst_n = 1'b1;
        #1;
        check("t6_async_perr", {31'h0, proto_err_o}, 32'h0);
        step();
        check("t6_eoc", {31'h0, eoc_o}, 32'h0);
        check("t6_exit", exit_code_o, 32'h0);
        check("t6_cvalid", {31'h0, char_valid_o}, 32'h0);
        check("t6_perr", {31'h0, proto_err_o}, 32'h0);
        rst_n = 1'b0;
        step();
        drive_aw(EOC, 8'h00); drive_w(32'h9, 4'hF, 1'b1);
        step(); clear_bus(); step();
        check("t6_clean_eoc", {31'h0, eoc_o}, 32'h1);
        check("t6_clean_exit", exit_code_o, 32'h9);
        check("t6_clean_perr", {31'h0, proto_err_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
